// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the core's SRAM-like bus: owner codes, the
// arbiter FSM encoding, transfer size codes and the request payload struct.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  // Owner code stored per outstanding transaction.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Transfer size codes: bytes = 1 << size.
  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  // Arbiter states: no lock, or grant held on inst / data.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_t;

  // Address-phase request fields presented on the master port.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which channel issued each outstanding transaction.
// Ports: clk, reset (sync, active-high); push/din write an owner code,
// pop retires the head; head/full/empty reflect registered state only.
module owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // Pointer advance that wraps at DEPTH, valid for non-power-of-two too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like master port between the
// instruction-fetch and data channels. Data has fixed priority; a presented
// but unaccepted grant is locked until accepted. Responses are routed back
// in issue order using an owner FIFO.
// Ports: clk, reset (sync, active-high);
//   inst_* / data_*: requester side (req/wr/size/wstrb/addr/wdata in,
//                    addr_ok/data_ok/rdata out);
//   mem_*:           master side (request fields out, addr_ok/data_ok/rdata in).
// The request, addr_ok and data_ok paths are combinational by design.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic     gnt_vld;
  logic     gnt_own;
  logic     gnt_req;
  logic     accept;
  logic     fifo_pop;
  logic     fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  bus_req_t inst_f;
  bus_req_t data_f;
  bus_req_t mem_f;

  assign inst_f = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                    addr: inst_addr, wdata: inst_wdata};
  assign data_f = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                    addr: data_addr, wdata: data_wdata};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant selection, master-port request, handshakes and next state.
  always_comb begin
    state_nxt    = state;
    gnt_vld      = 1'b0;
    gnt_own      = OWN_INST;
    gnt_req      = 1'b0;
    mem_req      = 1'b0;
    accept       = 1'b0;
    mem_f        = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (data_req) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_DATA;
        end else if (inst_req) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_INST;
        end
      end
      ARB_LOCK_I: begin
        gnt_vld = 1'b1;
        gnt_own = OWN_INST;
      end
      ARB_LOCK_D: begin
        gnt_vld = 1'b1;
        gnt_own = OWN_DATA;
      end
      default: begin
        gnt_vld = 1'b0;
      end
    endcase

    if (gnt_vld) begin
      gnt_req = (gnt_own == OWN_DATA) ? data_req : inst_req;
      mem_f   = (gnt_own == OWN_DATA) ? data_f : inst_f;
    end

    // Full uses registered occupancy, so a same-cycle pop does not unblock.
    mem_req      = gnt_req & ~fifo_full & ~reset;
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & (gnt_own == OWN_INST);
    data_addr_ok = accept & (gnt_own == OWN_DATA);

    case (state)
      ARB_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt = (gnt_own == OWN_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
        end
      end
      // A dropped request releases the lock (robustness only).
      ARB_LOCK_I: begin
        if (accept || !inst_req) begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_LOCK_D: begin
        if (accept || !data_req) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign mem_wr    = mem_f.wr;
  assign mem_size  = mem_f.size;
  assign mem_wstrb = mem_f.wstrb;
  assign mem_addr  = mem_f.addr;
  assign mem_wdata = mem_f.wdata;

  // Responses with nothing outstanding are dropped.
  assign fifo_pop     = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = fifo_pop & (fifo_head == OWN_INST);
  assign data_data_ok = fifo_pop & (fifo_head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (fifo_pop),
    .din   (gnt_own),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a vector table from the reset state, hand
// sequences for multi-cycle corners, then random traffic against a
// queue-based reference model.
module tb_sram_like_arbiter;

  localparam int unsigned MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // Reference model: list of outstanding owners (0 inst, 1 data) and the
  // channel whose grant is pinned (-1 when none).
  int owners[$];
  int lock_own = -1;
  int m_g;
  bit m_greq, m_emreq, m_acc, m_pop;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic zero_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Expected outputs for the current inputs, derived from the arbitration rules.
  task automatic model_check();
    logic [31:0] e_addr, e_wdata;
    logic [6:0]  e_ctl;
    bit full;
    m_g    = (lock_own >= 0) ? lock_own : (data_req ? 1 : (inst_req ? 0 : -1));
    m_greq = (m_g == 1) ? data_req : ((m_g == 0) ? inst_req : 1'b0);
    full   = (owners.size() >= MAX);
    m_emreq = !reset && m_greq && !full;
    m_acc  = m_emreq && mem_addr_ok;
    m_pop  = !reset && mem_data_ok && (owners.size() > 0);
    chk("mem_req", 32'(mem_req), 32'(m_emreq));
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(m_acc && m_g == 0));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(m_acc && m_g == 1));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(m_pop && owners[0] == 0));
    chk("data_data_ok", 32'(data_data_ok), 32'(m_pop && owners[0] == 1));
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    if (!reset) begin
      if (m_g == 1) begin
        e_addr = data_addr; e_wdata = data_wdata; e_ctl = {data_wr, data_size, data_wstrb};
      end else if (m_g == 0) begin
        e_addr = inst_addr; e_wdata = inst_wdata; e_ctl = {inst_wr, inst_size, inst_wstrb};
      end else begin
        e_addr = 0; e_wdata = 0; e_ctl = 0;
      end
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'(e_ctl));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      owners.delete();
      lock_own = -1;
    end else begin
      if (m_pop) void'(owners.pop_front());
      if (m_acc) owners.push_back(m_g);
      if (lock_own >= 0) begin
        if (m_acc || !m_greq) lock_own = -1;
      end else if (m_emreq && !mem_addr_ok) begin
        lock_own = m_g;
      end
    end
  endtask

  // One clock: model check before the edge, model update at the edge.
  task automatic cyc();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    zero_inputs();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  typedef struct {
    bit          ir, dr, aok;
    logic [31:0] ia, da;
    bit          e_mreq;
    logic [31:0] e_addr;
    bit          e_iaok, e_daok;
  } vec_t;

  vec_t vecs[6];

  initial begin
    reset = 1;
    zero_inputs();
    @(negedge clk);

    vecs[0] = '{0, 0, 1, 32'h1C00_0000, 32'h0000_1000, 0, 32'h0, 0, 0};
    vecs[1] = '{1, 0, 1, 32'h1C00_0000, 32'h0000_1000, 1, 32'h1C00_0000, 1, 0};
    vecs[2] = '{0, 1, 1, 32'h1C00_0000, 32'h0000_1000, 1, 32'h0000_1000, 0, 1};
    vecs[3] = '{1, 1, 1, 32'h1C00_0010, 32'h0000_2000, 1, 32'h0000_2000, 0, 1};
    vecs[4] = '{1, 1, 0, 32'h1C00_0020, 32'h0000_3000, 1, 32'h0000_3000, 0, 0};
    vecs[5] = '{1, 0, 0, 32'h1C00_0030, 32'h0000_4000, 1, 32'h1C00_0030, 0, 0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      inst_req = vecs[i].ir; data_req = vecs[i].dr; mem_addr_ok = vecs[i].aok;
      inst_addr = vecs[i].ia; data_addr = vecs[i].da;
      #1;
      chk("vec_mem_req", 32'(mem_req), 32'(vecs[i].e_mreq));
      chk("vec_mem_addr", mem_addr, vecs[i].e_addr);
      chk("vec_inst_addr_ok", 32'(inst_addr_ok), 32'(vecs[i].e_iaok));
      chk("vec_data_addr_ok", 32'(data_addr_ok), 32'(vecs[i].e_daok));
      cyc();
    end

    // Reset held with a pending fetch, then the first acceptance.
    zero_inputs();
    reset = 1; inst_req = 1; mem_addr_ok = 1; inst_addr = 32'h1C00_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_ok", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);
      cyc();
    end
    reset = 0;
    #1; chk("post_rst_inst_addr_ok", 32'(inst_addr_ok), 1);
    cyc();
    inst_req = 0; mem_data_ok = 1;
    #1; chk("post_rst_count1", 32'(inst_data_ok), 1);
    cyc();
    #1; chk("post_rst_drained", 32'(inst_data_ok), 0);
    cyc();

    // Simultaneous requests: data first, inst next cycle.
    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; data_req = 1; data_addr = 32'h0000_1000;
    mem_addr_ok = 1;
    #1;
    chk("both_mem_addr", mem_addr, 32'h0000_1000);
    chk("both_data_addr_ok", 32'(data_addr_ok), 1);
    chk("both_inst_addr_ok", 32'(inst_addr_ok), 0);
    cyc();
    data_req = 0;
    #1;
    chk("both_next_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("both_next_mem_addr", mem_addr, 32'h1C00_0000);
    cyc();

    // Lock on inst survives a rising data request.
    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0004; mem_addr_ok = 0;
    cyc(); cyc();
    data_req = 1; data_addr = 32'h0000_2000;
    #1;
    chk("lock_mem_addr", mem_addr, 32'h1C00_0004);
    chk("lock_data_addr_ok", 32'(data_addr_ok), 0);
    cyc();
    mem_addr_ok = 1;
    #1;
    chk("lock_accept", 32'(inst_addr_ok), 1);
    chk("lock_accept_addr", mem_addr, 32'h1C00_0004);
    cyc();
    inst_req = 0;
    #1;
    chk("lock_then_data", 32'(data_addr_ok), 1);
    chk("lock_then_data_addr", mem_addr, 32'h0000_2000);
    cyc();

    // Response ordering: data write, then inst read.
    do_reset();
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h3000;
    data_wdata = 32'h55; mem_addr_ok = 1;
    #1;
    chk("ord_wstrb", 32'(mem_wstrb), 32'h3);
    chk("ord_wr", 32'(mem_wr), 1);
    cyc();
    data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0008;
    cyc();
    inst_req = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ord_first_data", 32'(data_data_ok), 1);
    chk("ord_first_inst", 32'(inst_data_ok), 0);
    cyc();
    mem_rdata = 32'h1234_5678;
    #1;
    chk("ord_second_inst", 32'(inst_data_ok), 1);
    chk("ord_second_rdata", inst_rdata, 32'h1234_5678);
    chk("ord_second_data", 32'(data_data_ok), 0);
    cyc();

    // Full: third request held, pop frees a slot only on the next cycle.
    do_reset();
    inst_req = 1; mem_addr_ok = 1; inst_addr = 32'h1C00_0100;
    cyc(); cyc();
    #1; chk("full_mem_req", 32'(mem_req), 0);
    cyc();
    mem_data_ok = 1;
    #1; chk("full_pop_same_cycle", 32'(mem_req), 0);
    cyc();
    mem_data_ok = 0;
    #1;
    chk("full_after_pop", 32'(mem_req), 1);
    chk("full_after_pop_ok", 32'(inst_addr_ok), 1);
    cyc();
    inst_req = 0; mem_data_ok = 1;
    cyc(); cyc();
    #1; chk("spurious_no_ok", 32'({inst_data_ok, data_data_ok}), 0);
    cyc();
    mem_data_ok = 0; inst_req = 1;
    cyc();
    inst_req = 0; mem_data_ok = 1;
    #1; chk("count_stayed_zero_a", 32'(inst_data_ok), 1);
    cyc();
    #1; chk("count_stayed_zero_b", 32'(inst_data_ok), 0);
    cyc();

    // Reset with two outstanding discards them and returns to IDLE.
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    cyc(); cyc();
    reset = 1; mem_data_ok = 1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    cyc();
    reset = 0; data_req = 1; data_addr = 32'h4000; mem_addr_ok = 0;
    #1;
    chk("midrst_dropped", 32'({inst_data_ok, data_data_ok}), 0);
    chk("midrst_idle_grant", mem_addr, 32'h4000);
    chk("midrst_idle_req", 32'(mem_req), 1);
    cyc();

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) < 2);
      inst_req    = ($urandom_range(0, 99) < 55);
      data_req    = ($urandom_range(0, 99) < 45);
      inst_wr     = 1'($urandom);
      data_wr     = 1'($urandom);
      inst_size   = 2'($urandom_range(0, 2));
      data_size   = 2'($urandom_range(0, 2));
      inst_wstrb  = 4'($urandom);
      data_wstrb  = 4'($urandom);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = ($urandom_range(0, 99) < 60);
      mem_data_ok = ($urandom_range(0, 99) < 45);
      mem_rdata   = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
